// File: rtl/pwm_pkg.sv
// Shared definitions for the PWM generator and detector.
//   pwm_state_e        : FSM encoding (IDLE/HIGH/LOW)
//   DEFAULT_CNT_WIDTH  : default width of interval counts
package pwm_pkg;

  localparam int DEFAULT_CNT_WIDTH = 32;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_HIGH = 2'd1,
    ST_LOW  = 2'd2
  } pwm_state_e;

endpackage

// File: rtl/pwm_shadow_regs.sv
// Shadow/active double buffer for the PWM interval lengths.
//   clk, reset            : clock, synchronous active-high reset
//   load, high_in, low_in : software write strobe and requested lengths
//   apply                 : period boundary taken this cycle
//   active_high/low       : lengths governing the current period
//   next_high/low         : lengths that will govern the period a boundary starts
//   update_pending        : shadow holds values not yet applied
module pwm_shadow_regs
  import pwm_pkg::*;
#(
  parameter int CNT_WIDTH = DEFAULT_CNT_WIDTH
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 load,
  input  logic [CNT_WIDTH-1:0] high_in,
  input  logic [CNT_WIDTH-1:0] low_in,
  input  logic                 apply,
  output logic [CNT_WIDTH-1:0] active_high,
  output logic [CNT_WIDTH-1:0] active_low,
  output logic [CNT_WIDTH-1:0] next_high,
  output logic [CNT_WIDTH-1:0] next_low,
  output logic                 update_pending
);

  logic [CNT_WIDTH-1:0] shadow_high, shadow_low;

  // Only values loaded before the boundary cycle are visible here; a load
  // in the boundary cycle itself lands in the shadow for the next boundary.
  assign next_high = update_pending ? shadow_high : active_high;
  assign next_low  = update_pending ? shadow_low  : active_low;

  always_ff @(posedge clk) begin
    if (reset) begin
      shadow_high    <= '0;
      shadow_low     <= '0;
      active_high    <= '0;
      active_low     <= '0;
      update_pending <= 1'b0;
    end else begin
      if (apply && update_pending) begin
        active_high <= shadow_high;
        active_low  <= shadow_low;
      end
      if (load) begin
        shadow_high    <= high_in;
        shadow_low     <= low_in;
        update_pending <= 1'b1;
      end else if (apply) begin
        update_pending <= 1'b0;
      end
    end
  end

endmodule

// File: rtl/pwm_generator.sv
// Programmable PWM source: high and low phases last exactly the programmed
// number of clock cycles; new values take effect only at period boundaries.
//   clk, reset      : clock, synchronous active-high reset
//   enable          : 1 = run, 0 = idle with output low
//   load            : strobe capturing high_count_in/low_count_in
//   pwm_out         : registered PWM waveform
//   period_start    : pulse in the first cycle of each period
//   update_pending  : loaded values still waiting for a boundary
module pwm_generator
  import pwm_pkg::*;
#(
  parameter int CLK_FREQUENCY_HZ = 100000000,
  parameter int CNT_WIDTH        = DEFAULT_CNT_WIDTH
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 enable,
  input  logic                 load,
  input  logic [CNT_WIDTH-1:0] high_count_in,
  input  logic [CNT_WIDTH-1:0] low_count_in,
  output logic                 pwm_out,
  output logic                 period_start,
  output logic                 update_pending
);

  if (CLK_FREQUENCY_HZ <= 0) begin : g_bad_clk
    $error("pwm_generator: CLK_FREQUENCY_HZ must be positive");
  end

  pwm_state_e           state, bnd_state;
  logic [CNT_WIDTH-1:0] cnt;
  logic [CNT_WIDTH-1:0] active_high, active_low, next_high, next_low;
  logic                 at_end, boundary;

  pwm_shadow_regs #(.CNT_WIDTH(CNT_WIDTH)) u_shadow (
    .clk           (clk),
    .reset         (reset),
    .load          (load),
    .high_in       (high_count_in),
    .low_in        (low_count_in),
    .apply         (boundary),
    .active_high   (active_high),
    .active_low    (active_low),
    .next_high     (next_high),
    .next_low      (next_low),
    .update_pending(update_pending)
  );

  // A boundary is any point where a new period may begin: every enabled
  // IDLE cycle, the end of LOW, and the end of HIGH when there is no LOW
  // phase. The counter is compared by equality, so it never wraps.
  always_comb begin
    at_end   = (state == ST_HIGH && cnt == active_high) ||
               (state == ST_LOW  && cnt == active_low);
    boundary = enable && ((state == ST_IDLE) ||
               (at_end && !(state == ST_HIGH && active_low != '0)));
    if (next_high != '0)     bnd_state = ST_HIGH;
    else if (next_low != '0) bnd_state = ST_LOW;
    else                     bnd_state = ST_IDLE;
  end

  always_ff @(posedge clk) begin
    if (reset || !enable) begin
      state        <= ST_IDLE;
      cnt          <= '0;
      pwm_out      <= 1'b0;
      period_start <= 1'b0;
    end else if (boundary) begin
      state        <= bnd_state;
      cnt          <= (bnd_state == ST_IDLE) ? '0 : CNT_WIDTH'(1);
      pwm_out      <= (bnd_state == ST_HIGH);
      period_start <= (bnd_state != ST_IDLE);
    end else if (state == ST_HIGH && at_end) begin
      state        <= ST_LOW;
      cnt          <= CNT_WIDTH'(1);
      pwm_out      <= 1'b0;
      period_start <= 1'b0;
    end else begin
      cnt          <= cnt + CNT_WIDTH'(1);
      pwm_out      <= (state == ST_HIGH);
      period_start <= 1'b0;
    end
  end

endmodule

// File: doc/pwm_generator.md
Name: pwm_generator

Overview:
Programmable PWM source; the transmit-side counterpart to pwm_detector. Software (Microblaze GPIO) writes high/low interval lengths in clock cycles. The block emits a glitch-free PWM waveform whose high and low phases last exactly those counts. The output can be looped into pwm_detector for self-test; the detector then reports the programmed values unchanged.

Parameters:
CLK_FREQUENCY_HZ, 100000000, system clock frequency (documentation / derived constants only)
CNT_WIDTH, 32, width of interval counts and internal counter

Ports:
clk  input  1  system clock, 100 MHz
reset  input  1  synchronous, active-high reset
enable  input  1  level; 1 = generate waveform, 0 = force idle (output low)
load  input  1  single-cycle strobe; captures high_count_in/low_count_in into shadow registers
high_count_in  input  CNT_WIDTH  requested high-phase length, cycles
low_count_in  input  CNT_WIDTH  requested low-phase length, cycles
pwm_out  output  1  registered PWM output
period_start  output  1  one-cycle pulse, asserted in the first cycle of each new period (first high cycle, or first low cycle when high length is 0)
update_pending  output  1  shadow holds values not yet applied to the active registers

Behaviour:
- Reset (sync, highest priority): state IDLE; pwm_out=0, period_start=0, update_pending=0; shadow and active high/low = 0; counter = 0. Reset asserted mid-period aborts immediately; pwm_out is 0 the cycle after.
- load=1: shadow_high/low <= inputs; update_pending <= 1. Repeated loads before a boundary overwrite the shadow; the last one wins.
- Active registers change only at a period boundary. They copy the shadow if update_pending was 1 in the cycle before the boundary; update_pending then clears.
  - load in the boundary cycle itself goes to the shadow only, applies at the next boundary, and leaves update_pending=1.
  - Same rule applies to the IDLE->run transition.
- FSM states: IDLE, HIGH, LOW.
  - pwm_out is registered: 1 exactly when the next state is HIGH.
  - IDLE: pwm_out=0. If enable=1, take a boundary:
    - go HIGH if new active_high != 0;
    - else LOW if active_low != 0;
    - else stay IDLE, with no period_start.
  - HIGH: counter runs 1..active_high.
    - On the cycle the counter equals active_high: go LOW if active_low != 0.
    - Otherwise take a boundary, staying HIGH (constant-high output).
  - LOW: counter runs 1..active_low.
    - On the cycle the counter equals active_low: take a boundary to HIGH.
    - If the new active_high is 0, take a boundary to LOW instead (constant-low output, period_start every L cycles).
  - Any state with enable=0: go to IDLE next cycle, pwm_out=0. A partial period is discarded, and no period_start is issued.
- Latency: enable rising in cycle N with H>0 gives pwm_out=1 and period_start=1 registered at the end of N, i.e. visible in cycle N+1.
- Phase lengths: pwm_out stays high for exactly active_high consecutive cycles, then low for exactly active_low cycles. Period = H+L cycles.
- Arithmetic: counter is CNT_WIDTH unsigned and compared by equality, so it never wraps. Max count 2^CNT_WIDTH-1 is legal.
- Both active values 0 while running: return to IDLE, pwm_out=0. Resume automatically at the next load with nonzero values, provided enable=1.

Decomposition:
- Shared package pwm_pkg:
  - state encoding constants (IDLE=2'd0, HIGH=2'd1, LOW=2'd2);
  - default CNT_WIDTH.
- Same package is usable by pwm_detector.
- Natural sub-module: pwm_shadow_regs (shadow/active double buffer, update_pending flag, boundary apply). The FSM and counter remain in pwm_generator.

Test Plan:
- Loopback: reset, load H=3 L=5, enable=1, drive pwm_detector from pwm_out -> after the second rising edge the detector shows high_count=3, low_count=5. pwm_out pattern is 11100000 repeating; period_start every 8 cycles.
- Mid-period update: running H=4 L=4; load H=2 L=6 during the HIGH phase -> current period completes 4/4 and update_pending=1. The next period is 2/6; update_pending clears at its boundary.
- Edge duty: load H=0 L=7 -> pwm_out constant 0, period_start every 7 cycles. Then load H=7 L=0 -> pwm_out constant 1 from the next boundary, period_start every 7 cycles.
- Load coincident with boundary: H=2 L=2, load H=5 L=1 exactly on a period_start cycle -> the period just started stays 2/2; 5/1 applies at the following boundary.
- Enable/reset mid-operation: drop enable during LOW -> pwm_out=0 next cycle and IDLE. Re-enable -> full H restarts with period_start. Assert reset during HIGH -> all outputs 0 next cycle; shadow cleared, so re-enable with no load keeps pwm_out=0.
- Maximum count: load H=2^32-1 L=1 (shortened in sim via CNT_WIDTH=4: H=15 L=1) -> 15 high, 1 low, no counter wrap.
